pe_spad: RTL
============

# pe_spad

Parametrised processing element with on-chip scratchpads. It holds up to `MAX_P × MAX_Q` filter weights and computes `p` output channels per output position by sweeping each ifmap value across all resident filters. For each of `F` positions it merges the results with incoming partial sums, then emits `p` opsums. It sits in the PE array in place of the single-MAC PE and is driven by the same valid/ready GLB/NoC interfaces.

## Interface
Parameters:
- `DATA_BITS`, default 32: width of all data buses.
- `IFMAP_BITS`, default 8: unsigned ifmap field, in bus bits `[IFMAP_BITS-1:0]`.
- `FILTER_BITS`, default 8: signed weight field, in bus bits `[FILTER_BITS-1:0]`.
- `PSUM_BITS`, default 32: accumulator width; must be `<= DATA_BITS`.
- `IFMAP_ZP`, default 128: ifmap zero point.
- `MAX_P`, default 4; `MAX_Q`, default 4: scratchpad depth is `MAX_P*MAX_Q`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: clock.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Control:
  - `PE_en`, in, 1: start request, sampled in IDLE.
  - `i_config`, in, 10: `[9]` is_fc, `[8:7]` p-1, `[6:2]` F-1, `[1:0]` q-1.
- Input handshakes:
  - `filter`, in, DATA_BITS; `filter_valid`, in, 1; `filter_ready`, out, 1.
  - `ifmap`, in, DATA_BITS; `ifmap_valid`, in, 1; `ifmap_ready`, out, 1.
  - `ipsum`, in, DATA_BITS; `ipsum_valid`, in, 1; `ipsum_ready`, out, 1.
- Output handshake:
  - `opsum`, out, DATA_BITS; `opsum_valid`, out, 1; `opsum_ready`, in, 1.
- `done`, out, 1: one-cycle pulse when the job completes.

## Operation
- Config (p, q, F, is_fc) is latched on the cycle IDLE sees `PE_en=1`. Config changes after that are ignored. If `is_fc=1`, F is forced to 1.
- LOAD_F: accepts `p*q` filter words, k-major. Word `k*q+c` holds filter k, channel c. The next state is LOAD_I.
- LOAD_I: accepts one ifmap word for channel c (c = 0..q-1 within each position), then goes to MAC.
- MAC: exactly p cycles; cycle k computes `acc[k] += x*w[k*q+c]`.
  - `x = ifmap[IFMAP_BITS-1:0] - IFMAP_ZP`, signed, IFMAP_BITS+1 bits.
  - The weight is sign-extended.
  - The product is sign-extended to PSUM_BITS and accumulated modulo 2^PSUM_BITS.
  - After the last MAC cycle: if c<q-1, go back to LOAD_I; otherwise go to PSUM.
- PSUM: for k = 0..p-1, each ipsum fire registers `opsum <= ipsum[PSUM_BITS-1:0] + acc[k]`, sign-extended to DATA_BITS, and sets `opsum_valid`.
  - After the p-th output has been accepted downstream: if position < F-1, clear acc and go to LOAD_I; otherwise go to DONE.
- DONE: asserts `done` for 1 cycle, then goes to IDLE. Filters stay resident but are reloaded on every job.
- `acc[0..p-1]` is cleared on entry to each position.
- Entries for k ≥ p are unused.

## Timing
- Reset values:
  - state is IDLE.
  - all ready outputs, `opsum_valid` and `done` are 0.
  - `opsum`, all acc entries and all counters are 0.
  - Scratchpad contents are don't-care.
- Ready/fire rules:
  - `filter_ready = (state==LOAD_F)`.
  - `ifmap_ready = (state==LOAD_I)`.
  - `ipsum_ready = (state==PSUM) && (!opsum_valid || opsum_ready)`.
  - A fire happens when valid&&ready in the same cycle.
- `opsum_valid` holds and `opsum` stays stable until `opsum_ready`. A fire with a simultaneous new ipsum fire reloads opsum in the same cycle, with no bubble.
- Per-position latency with no stalls: `q*(1+p)` cycles, plus p cycles in PSUM, plus 1 cycle of drain for the last opsum.
- `PE_en` is ignored outside IDLE; deasserting it mid-job does not abort.
- `rst_n` low at any time returns all outputs to their reset values asynchronously. Any partial job is discarded.
- Inputs with valid asserted while ready is low are not consumed.

## Structure
- Shared package `pe_pkg` holds:
  - the state enum `pe_state_t` (IDLE, LOAD_F, LOAD_I, MAC, PSUM, DONE).
  - the config field bit positions.
  - a packed `pe_cfg_t` struct with a decode function.
- Natural sub-module: `pe_spad_rf`, a `MAX_P*MAX_Q × FILTER_BITS` register file with 1 write port and 1 combinational read port.
- Counters (k, c, position) and the acc array live in the top level.

## Test plan
- p=1, q=1, F=1; filter 3, ifmap 130, ipsum 10 → one opsum = 16 (x=2), then a `done` pulse.
- p=2, q=2, F=1; filters 1,2,3,4; ifmaps 129,131; ipsums 0,100 → opsums 7 then 115.
- Extremes: filter 0x80 (−128), ifmap 0 (x=−128), ipsum −1 → opsum 16383. A separate case with ipsum 0x7FFFFFFF and product 1 wraps to 0x80000000.
- Backpressure in case 2: hold `opsum_ready` low for 5 cycles → `opsum` stays 7, `ipsum_ready` stays 0, no data is lost, and the final sequence is unchanged.
- is_fc=1 with F field=3, p=1, q=1 → exactly 1 ifmap is consumed, 1 opsum is emitted, then `done`. A 4-position job with is_fc=0 emits 4 opsums.
- Assert `rst_n` low during MAC of case 2 → all outputs are 0 immediately. A subsequent fresh job reproduces 7 and 115 exactly.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the scratchpad PE: FSM states, config word layout and decode.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_I,
        MAC,
        PSUM,
        DONE
    } pe_state_t;

    localparam int CFG_W      = 10;
    localparam int CFG_FC_BIT = 9;
    localparam int CFG_P_LSB  = 7;
    localparam int CFG_P_W    = 2;
    localparam int CFG_F_LSB  = 2;
    localparam int CFG_F_W    = 5;
    localparam int CFG_Q_LSB  = 0;
    localparam int CFG_Q_W    = 2;

    typedef struct packed {
        logic                 is_fc;
        logic [CFG_P_W-1:0]   p_m1;
        logic [CFG_F_W-1:0]   f_m1;
        logic [CFG_Q_W-1:0]   q_m1;
    } pe_cfg_t;

    // Fully-connected jobs only ever have a single output position.
    function automatic pe_cfg_t decode_cfg(input logic [CFG_W-1:0] raw);
        pe_cfg_t cfg;
        cfg.is_fc = raw[CFG_FC_BIT];
        cfg.p_m1  = raw[CFG_P_LSB +: CFG_P_W];
        cfg.f_m1  = raw[CFG_FC_BIT] ? '0 : raw[CFG_F_LSB +: CFG_F_W];
        cfg.q_m1  = raw[CFG_Q_LSB +: CFG_Q_W];
        return cfg;
    endfunction

endpackage

// File: rtl/pe_spad_if.sv
// Valid/ready GLB/NoC bundle between the PE and its feeders/consumer.
interface pe_spad_if #(
    parameter int DATA_BITS = 32
);
    logic [DATA_BITS-1:0] filter;
    logic                 filter_valid;
    logic                 filter_ready;
    logic [DATA_BITS-1:0] ifmap;
    logic                 ifmap_valid;
    logic                 ifmap_ready;
    logic [DATA_BITS-1:0] ipsum;
    logic                 ipsum_valid;
    logic                 ipsum_ready;
    logic [DATA_BITS-1:0] opsum;
    logic                 opsum_valid;
    logic                 opsum_ready;

    modport slave (
        input  filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        output filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );

    modport master (
        output filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        input  filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_spad_rf.sv
// Filter scratchpad: one synchronous write port, one combinational read port.
module pe_spad_rf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pe_spad.sv
// Processing element holding p*q resident filters; each ifmap value is swept
// across all p filters, then merged with incoming psums per output position.
module pe_spad
    import pe_pkg::*;
#(
    parameter int DATA_BITS   = 32,
    parameter int IFMAP_BITS  = 8,
    parameter int FILTER_BITS = 8,
    parameter int PSUM_BITS   = 32,
    parameter int IFMAP_ZP    = 128,
    parameter int MAX_P       = 4,
    parameter int MAX_Q       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PE_en,
    input  logic [CFG_W-1:0] i_config,
    pe_spad_if.slave         pe_bus,
    output logic             done
);
    localparam int DEPTH = MAX_P * MAX_Q;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(MAX_P);
    localparam int KCW   = KW + 1;
    localparam int PW    = IFMAP_BITS + FILTER_BITS + 1;
    localparam logic [IFMAP_BITS:0] ZP_EXT = (IFMAP_BITS+1)'(IFMAP_ZP);

    pe_state_t r_state, w_next;
    pe_cfg_t   r_cfg;

    logic [KCW-1:0]            r_k;
    logic [CFG_Q_W-1:0]        r_c;
    logic [CFG_F_W-1:0]        r_pos;
    logic signed [IFMAP_BITS:0] r_x;
    logic [PSUM_BITS-1:0]      r_acc [MAX_P];
    logic [DATA_BITS-1:0]      r_opsum;
    logic                      r_opsum_valid;

    logic                      w_filter_fire, w_ifmap_fire, w_ipsum_fire, w_opsum_fire;
    logic                      w_k_last, w_c_last, w_pos_last, w_psum_all, w_drain;
    logic [KCW-1:0]            w_p_count;
    logic [KW-1:0]             w_kidx;
    logic [AW-1:0]             w_addr;
    logic signed [FILTER_BITS-1:0] w_weight;
    logic signed [PW-1:0]      w_prod;
    logic [PSUM_BITS-1:0]      w_prod_ext;
    logic [PSUM_BITS-1:0]      w_sum;
    logic                      w_unused;

    assign w_p_count  = KCW'(r_cfg.p_m1) + KCW'(1);
    assign w_kidx     = r_k[KW-1:0];
    assign w_k_last   = (r_k == KCW'(r_cfg.p_m1));
    assign w_c_last   = (r_c == r_cfg.q_m1);
    assign w_pos_last = (r_pos == r_cfg.f_m1);
    assign w_psum_all = (r_k == w_p_count);

    // Filters are k-major, so the same address serves loading and MAC.
    assign w_addr = AW'(r_k) * AW'({1'b0, r_cfg.q_m1} + 3'd1) + AW'(r_c);

    assign pe_bus.filter_ready = (r_state == LOAD_F);
    assign pe_bus.ifmap_ready  = (r_state == LOAD_I);
    assign pe_bus.ipsum_ready  = (r_state == PSUM) && !w_psum_all
                                 && (!r_opsum_valid || pe_bus.opsum_ready);
    assign pe_bus.opsum        = r_opsum;
    assign pe_bus.opsum_valid  = r_opsum_valid;
    assign done                = (r_state == DONE);

    assign w_filter_fire = pe_bus.filter_valid && pe_bus.filter_ready;
    assign w_ifmap_fire  = pe_bus.ifmap_valid  && pe_bus.ifmap_ready;
    assign w_ipsum_fire  = pe_bus.ipsum_valid  && pe_bus.ipsum_ready;
    assign w_opsum_fire  = r_opsum_valid && pe_bus.opsum_ready;
    assign w_drain       = (r_state == PSUM) && w_psum_all && w_opsum_fire;

    assign w_prod     = PW'(r_x) * PW'(w_weight);
    assign w_prod_ext = PSUM_BITS'(w_prod);
    assign w_sum      = pe_bus.ipsum[PSUM_BITS-1:0] + r_acc[w_kidx];
    assign w_unused   = ^{pe_bus.ifmap[DATA_BITS-1:IFMAP_BITS],
                          pe_bus.filter[DATA_BITS-1:FILTER_BITS], r_cfg.is_fc};

    pe_spad_rf #(
        .DEPTH (DEPTH),
        .WIDTH (FILTER_BITS)
    ) u_rf (
        .clk     (clk),
        .i_we    (w_filter_fire),
        .i_waddr (w_addr),
        .i_wdata (pe_bus.filter[FILTER_BITS-1:0]),
        .i_raddr (w_addr),
        .o_rdata (w_weight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (PE_en) w_next = LOAD_F;
            LOAD_F:  if (w_filter_fire && w_k_last && w_c_last) w_next = LOAD_I;
            LOAD_I:  if (w_ifmap_fire) w_next = MAC;
            MAC:     if (w_k_last) w_next = w_c_last ? PSUM : LOAD_I;
            PSUM:    if (w_drain) w_next = w_pos_last ? DONE : LOAD_I;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg         <= '0;
            r_k           <= '0;
            r_c           <= '0;
            r_pos         <= '0;
            r_x           <= '0;
            r_opsum       <= '0;
            r_opsum_valid <= 1'b0;
            for (int i = 0; i < MAX_P; i++) r_acc[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (PE_en) begin
                    r_cfg <= decode_cfg(i_config);
                    r_k   <= '0;
                    r_c   <= '0;
                    r_pos <= '0;
                    for (int i = 0; i < MAX_P; i++) r_acc[i] <= '0;
                end
                LOAD_F: if (w_filter_fire) begin
                    if (w_c_last) begin
                        r_c <= '0;
                        r_k <= w_k_last ? '0 : r_k + KCW'(1);
                    end else begin
                        r_c <= r_c + 2'd1;
                    end
                end
                LOAD_I: if (w_ifmap_fire)
                    r_x <= $signed({1'b0, pe_bus.ifmap[IFMAP_BITS-1:0]} - ZP_EXT);
                MAC: begin
                    r_acc[w_kidx] <= r_acc[w_kidx] + w_prod_ext;
                    if (w_k_last) begin
                        r_k <= '0;
                        r_c <= w_c_last ? '0 : r_c + 2'd1;
                    end else begin
                        r_k <= r_k + KCW'(1);
                    end
                end
                PSUM: begin
                    // A new ipsum may refill opsum in the same cycle the old one leaves.
                    if (w_ipsum_fire) begin
                        r_opsum       <= DATA_BITS'($signed(w_sum));
                        r_opsum_valid <= 1'b1;
                        r_k           <= r_k + KCW'(1);
                    end else if (w_opsum_fire) begin
                        r_opsum_valid <= 1'b0;
                    end
                    if (w_drain) begin
                        r_k   <= '0;
                        r_pos <= r_pos + 5'd1;
                        for (int i = 0; i < MAX_P; i++) r_acc[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
